ctrl_conditioner: RTL and testbench

// - Conditions raw player buttons into the 6-bit control word read by the character/menu sprite stages (i_ctrl).
// - Pipeline: 2-flop sync -> per-button debounce -> edge detect -> frame-aligned control latch.
// - Sits directly upstream of the sprite movement FSMs.
// - o_ctrl changes only on the i_frame strobe, so sprite motion is frame-coherent.
// - A press shorter than one frame is never lost.

---
 rtl/ctrl_conditioner_if.sv | 23 ++
 rtl/ctrl_conditioner.sv | 118 +++++++++++
 tb/tb_ctrl_conditioner.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/ctrl_conditioner_if.sv
// Button-conditioner bus: raw button/frame inputs and conditioned outputs.
// slave = conditioner side, master = driver/consumer side.
interface ctrl_conditioner_if #(
    parameter int N_BTN = 6
);
    logic [N_BTN-1:0] i_btn;
    logic             i_frame;
    logic [N_BTN-1:0] o_db;
    logic [N_BTN-1:0] o_press;
    logic [N_BTN-1:0] o_release;
    logic             o_any;
    logic [N_BTN-1:0] o_ctrl;

    modport slave (
        input  i_btn, i_frame,
        output o_db, o_press, o_release, o_any, o_ctrl
    );

    modport master (
        output i_btn, i_frame,
        input  o_db, o_press, o_release, o_any, o_ctrl
    );
endinterface

// File: rtl/ctrl_conditioner.sv
// ctrl_conditioner: raw buttons -> 2-flop sync -> per-bit debounce ->
// edge pulses -> frame-aligned control word for the sprite stage.
// Optional feature macro: CTRL_AUTOREPEAT_EN (frame-based auto-repeat of
// o_press while a button is held). Default build has no repeat logic.
module ctrl_conditioner #(
    parameter int N_BTN        = 6,
    parameter int DEBOUNCE_CYC = 200000,
    parameter int REPEAT_DELAY = 30,
    parameter int REPEAT_RATE  = 6
) (
    input  logic                i_clk_pix,
    input  logic                i_rst_n,
    ctrl_conditioner_if.slave   bus
);
    localparam int CNTW = $clog2(DEBOUNCE_CYC + 1);

    // Parameter sanity: elaboration-time only.
    if (DEBOUNCE_CYC < 2) begin : g_bad_deb
        $error("DEBOUNCE_CYC must be >= 2");
    end
    if (REPEAT_DELAY < 2 || REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DELAY) begin : g_bad_rpt
        $error("REPEAT_DELAY/REPEAT_RATE out of range");
    end

    logic [N_BTN-1:0]           s1, s2;
    logic [N_BTN-1:0][CNTW-1:0] cnt;
    logic [N_BTN-1:0]           db, press, release_q, ctrl, pend;
    logic                       any;
    logic [N_BTN-1:0]           rise, fall, rpt;

    assign bus.o_db      = db;
    assign bus.o_press   = press;
    assign bus.o_release = release_q;
    assign bus.o_any     = any;
    assign bus.o_ctrl    = ctrl;

    // Acceptance of a debounced edge this cycle (count saturated while differing).
    always_comb begin
        rise = '0;
        fall = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (s2[i] != db[i] && cnt[i] == CNTW'(DEBOUNCE_CYC - 1)) begin
                rise[i] = s2[i];
                fall[i] = ~s2[i];
            end
        end
    end

`ifdef CTRL_AUTOREPEAT_EN
    localparam int HCW = $clog2(REPEAT_DELAY + 1);
    logic [N_BTN-1:0][HCW-1:0] hc;

    // Repeat fires on the frame where the held count reaches its limit.
    always_comb begin
        rpt = '0;
        for (int i = 0; i < N_BTN; i++)
            rpt[i] = bus.i_frame & db[i] & (hc[i] == HCW'(REPEAT_DELAY - 1));
    end

    // Per-bit held-frame counters; first repeat after REPEAT_DELAY frames,
    // then every REPEAT_RATE frames by reloading part-way.
    always_ff @(posedge i_clk_pix) begin
        if (!i_rst_n) begin
            hc <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (!db[i])
                    hc[i] <= '0;
                else if (bus.i_frame) begin
                    if (rpt[i])
                        hc[i] <= HCW'(REPEAT_DELAY - REPEAT_RATE);
                    else
                        hc[i] <= hc[i] + HCW'(1);
                end
            end
        end
    end
`else
    assign rpt = '0;
`endif

    // Sync, debounce, edge pulses and the frame-aligned control latch.
    always_ff @(posedge i_clk_pix) begin
        if (!i_rst_n) begin
            s1        <= '0;
            s2        <= '0;
            cnt       <= '0;
            db        <= '0;
            press     <= '0;
            release_q <= '0;
            any       <= 1'b0;
            ctrl      <= '0;
            pend      <= '0;
        end else begin
            s1 <= bus.i_btn;
            s2 <= s1;
            for (int i = 0; i < N_BTN; i++) begin
                if (s2[i] == db[i])
                    cnt[i] <= '0;
                else if (cnt[i] == CNTW'(DEBOUNCE_CYC - 1)) begin
                    db[i]  <= s2[i];
                    cnt[i] <= '0;
                end else
                    cnt[i] <= cnt[i] + CNTW'(1);
            end
            press     <= rise | rpt;
            release_q <= fall;
            any       <= |(rise | rpt);
            // Frame clear wins over a coincident press; db already holds the bit.
            if (bus.i_frame) begin
                ctrl <= db | pend;
                pend <= '0;
            end else begin
                pend <= pend | press;
            end
        end
    end
endmodule

// File: tb/tb_ctrl_conditioner.sv
// Scoreboard bench for ctrl_conditioner: stimulus pushes expected events
// (press / release / control-word change) with their cycle; a monitor pops
// and compares whenever the DUT shows one of them.
module tb_ctrl_conditioner;
    localparam int KP = 0, KR = 1, KC = 2;

    typedef struct {
        int         cyc;
        int         kind;
        logic [5:0] val;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    bit   mon_en = 1'b0;
    logic [5:0] prev_ctrl = '0;
    ev_t  q[$];

    ctrl_conditioner_if #(.N_BTN(6)) bus ();

    ctrl_conditioner #(
        .N_BTN(6), .DEBOUNCE_CYC(4), .REPEAT_DELAY(3), .REPEAT_RATE(2)
    ) dut (
        .i_clk_pix(clk),
        .i_rst_n  (rst_n),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Frame strobe sampled at edges 20, 40, 60, ...
    initial begin
        bus.i_frame = 1'b0;
        forever begin
            @(negedge clk);
            bus.i_frame = (cyc % 20 == 19);
        end
    end

    task automatic push(input int c, input int k, input logic [5:0] v);
        ev_t e;
        e.cyc = c; e.kind = k; e.val = v;
        q.push_back(e);
    endtask

    task automatic at(input int n);
        do @(negedge clk); while (cyc < n);
    endtask

    task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_db"},  bus.o_db, 6'h00);
        chk({tag, "_prs"}, bus.o_press, 6'h00);
        chk({tag, "_rel"}, bus.o_release, 6'h00);
        chk({tag, "_any"}, {5'd0, bus.o_any}, 6'h00);
        chk({tag, "_ctl"}, bus.o_ctrl, 6'h00);
    endtask

    task automatic pop_cmp(input int kind, input logic [5:0] val, input bit extra_ok);
        ev_t e;
        tests++;
        if (q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_ev kind %0d @cyc %0d val %h (none expected)", kind, cyc, val);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.val !== val || !extra_ok) begin
                fails++;
                $display("FAIL event: got kind %0d cyc %0d val %h any_ok %0d, want kind %0d cyc %0d val %h",
                         kind, cyc, val, extra_ok, e.kind, e.cyc, e.val);
            end
        end
    endtask

    // Monitor: compare every visible output event against the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.o_press != 6'h00 || bus.o_any)
                pop_cmp(KP, bus.o_press, bus.o_any == (|bus.o_press));
            if (bus.o_release != 6'h00)
                pop_cmp(KR, bus.o_release, 1'b1);
            if (bus.o_ctrl !== prev_ctrl) begin
                pop_cmp(KC, bus.o_ctrl, 1'b1);
                prev_ctrl = bus.o_ctrl;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d events outstanding", q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.i_btn = '0;
        at(2);
        chk_rst("reset");
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Clean press on jump: accepted 6 cycles after the input edge.
        at(3);  bus.i_btn[4] = 1'b1;
        push(9, KP, 6'h10);
        push(20, KC, 6'h10);
        push(31, KR, 6'h10);
        push(40, KC, 6'h00);
        at(8);  chk("lat_db_before", bus.o_db, 6'h00);
        at(9);  chk("lat_db_at", bus.o_db, 6'h10);
        at(25); bus.i_btn[4] = 1'b0;

        // Three-cycle glitch on left: must never be accepted.
        at(42); bus.i_btn[0] = 1'b1;
        at(45); bus.i_btn[0] = 1'b0;
        at(50); chk("glitch_db", bus.o_db, 6'h00);

        // Short tap on right inside one frame: o_ctrl high for one frame.
        at(59); bus.i_btn[1] = 1'b1;
        push(65, KP, 6'h02);
        push(72, KR, 6'h02);
        push(80, KC, 6'h02);
        push(100, KC, 6'h00);
        at(66); bus.i_btn[1] = 1'b0;

        // Press coincident with frame; pend[4] must not survive the frame.
        at(113); bus.i_btn[4] = 1'b1;
        push(119, KP, 6'h10);
        push(120, KC, 6'h10);
        at(122); bus.i_btn[4] = 1'b0;
        at(124); bus.i_btn[5] = 1'b1;
        push(128, KR, 6'h10);
        push(130, KP, 6'h20);
        push(140, KC, 6'h20);

        // Reset while bit 1 is mid-count (cnt=2), bit 5 held and latched.
        at(142); bus.i_btn[1] = 1'b1;
        at(146); rst_n = 1'b0;
        push(147, KC, 6'h00);
        at(147); chk_rst("midreset"); rst_n = 1'b1;
        push(153, KP, 6'h22);
        push(160, KC, 6'h22);
        push(171, KR, 6'h22);
        push(180, KC, 6'h00);
        at(152); chk("rst_db_before", bus.o_db, 6'h00);
        at(153); chk("rst_db_at", bus.o_db, 6'h22);
        at(165); bus.i_btn[1] = 1'b0; bus.i_btn[5] = 1'b0;

        // Long hold on left: repeats only with the auto-repeat build.
        at(183); bus.i_btn[0] = 1'b1;
        push(189, KP, 6'h01);
        push(200, KC, 6'h01);
`ifdef CTRL_AUTOREPEAT_EN
        push(241, KP, 6'h01);
        push(281, KP, 6'h01);
        push(291, KR, 6'h01);
        push(320, KC, 6'h00);
`else
        push(291, KR, 6'h01);
        push(300, KC, 6'h00);
`endif
        at(285); bus.i_btn[0] = 1'b0;

        at(330);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL leftover: %0d expected events never seen, want 0 (next cyc %0d kind %0d)",
                     q.size(), q[0].cyc, q[0].kind);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
